// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam logic [1:0]  IFU_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    REQ      = 3'd0,
    WAIT_RSP = 3'd1,
    HOLD     = 3'd2,
    WAIT_WB  = 3'd3,
    ERR      = 3'd4
  } ifu_state_t;

  // Instructions are word aligned; any low address bit set is a fault.
  function automatic logic ifu_misaligned(input logic [1:0] lsb);
    return (lsb & IFU_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch bus bundle: memory request/response and the decode-side handshake.
interface ifu_fetch_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  modport master (
    output req_valid, req_addr, rsp_ready, out_valid, out_inst, out_pc,
    input  req_ready, rsp_valid, rsp_data, rsp_err, out_ready
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, out_valid, out_inst, out_pc,
    output req_ready, rsp_valid, rsp_data, rsp_err, out_ready
  );
endinterface

// File: rtl/ifu_perf_cnt.sv
// Single saturating 32-bit event counter.
module ifu_perf_cnt (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        inc,
  output logic [31:0] cnt
);
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)
      cnt <= '0;
    else if (inc && (cnt != 32'hFFFF_FFFF))
      cnt <= cnt + 32'd1;
  end
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle fetch FSM: one instruction in flight, next PC taken from write-back.
// Optional performance counters under IFU_PERF_CNT_EN.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  ifu_fetch_ctrl_if.master   bus,
  input  logic               wb_valid,
  input  logic [XLEN-1:0]    wb_dnpc,
  output logic [XLEN-1:0]    pc,
  output logic               fetch_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  ifu_state_t      state;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        REQ:
          if (bus.req_ready) state <= WAIT_RSP;
        WAIT_RSP:
          if (bus.rsp_valid) begin
            if (bus.rsp_err) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              inst_q    <= bus.rsp_data;
              inst_pc_q <= pc;
              state     <= HOLD;
            end
          end
        HOLD:
          if (bus.out_ready) state <= WAIT_WB;
        WAIT_WB:
          if (wb_valid) begin
            pc <= wb_dnpc;
            if (ifu_misaligned(wb_dnpc[1:0])) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              state     <= REQ;
            end
          end
        ERR:     state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

  // Handshakes are decoded from state, but forced low while reset is held.
  assign bus.req_valid = rst && (state == REQ);
  assign bus.rsp_ready = rst && (state == WAIT_RSP);
  assign bus.out_valid = rst && (state == HOLD);
  assign bus.req_addr  = pc;
  assign bus.out_inst  = inst_q;
  assign bus.out_pc    = inst_pc_q;

`ifdef IFU_PERF_CNT_EN
  logic fetch_evt;
  logic stall_evt;

  assign fetch_evt = (state == WAIT_RSP) && bus.rsp_valid && !bus.rsp_err;
  assign stall_evt = ((state == REQ) && !bus.req_ready) ||
                     ((state == WAIT_RSP) && !bus.rsp_valid);

  ifu_perf_cnt u_fetch_cnt (
    .gclk   (clk),
    .grst_n (rst),
    .inc    (fetch_evt),
    .cnt    (perf_fetch_cnt)
  );

  ifu_perf_cnt u_stall_cnt (
    .gclk   (clk),
    .grst_n (rst),
    .inc    (stall_evt),
    .cnt    (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Transaction-level bench for ifu_fetch_ctrl with randomized peer timing.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_dnpc;
  logic [31:0] pc;
  logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ifu_fetch_ctrl_if #(.XLEN(32)) bus ();

  ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wb_valid  (wb_valid),
    .wb_dnpc   (wb_dnpc),
    .pc        (pc),
    .fetch_err (fetch_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;
  int          m_fetch;
  int          m_stall;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    bus.out_ready = 1'b0;
    wb_valid      = 1'b0;
    wb_dnpc       = '0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    m_pc    = RST_PC;
    m_fetch = 0;
    m_stall = 0;
  endtask

  // One complete instruction as seen from the bus; delays are the number of
  // cycles each peer holds off before completing its handshake.
  task automatic run_instr(input logic [31:0] data, input int rw, input int sw,
                           input int ow, input int ww, input logic [31:0] dnpc);
    for (int i = 0; i < rw; i++) begin
      bus.rsp_valid = 1'($urandom_range(0, 1));
      bus.rsp_data  = $urandom;
      wb_valid      = 1'($urandom_range(0, 1));
      wb_dnpc       = 32'h8000_1000;
      n_cmp++;
      if (bus.req_valid !== 1'b1 || bus.req_addr !== m_pc || bus.rsp_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL req_wait: valid=%b addr=%h rsp_ready=%b, want valid=1 addr=%h rsp_ready=0",
                 bus.req_valid, bus.req_addr, bus.rsp_ready, m_pc);
      end
      tick();
    end
    bus.req_ready = 1'b1;
    n_cmp++;
    if (bus.req_valid !== 1'b1 || bus.req_addr !== m_pc) begin
      n_bad++;
      $display("FAIL req_accept: valid=%b addr=%h, want valid=1 addr=%h",
               bus.req_valid, bus.req_addr, m_pc);
    end
    tick();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    for (int i = 0; i < sw; i++) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_dnpc  = 32'h8000_1000;
      n_cmp++;
      if (bus.rsp_ready !== 1'b1 || bus.req_valid !== 1'b0 || bus.out_valid !== 1'b0 ||
          pc !== m_pc) begin
        n_bad++;
        $display("FAIL rsp_wait: rsp_ready=%b req_valid=%b out_valid=%b pc=%h, want 1/0/0 pc=%h",
                 bus.rsp_ready, bus.req_valid, bus.out_valid, pc, m_pc);
      end
      tick();
    end
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = data;
    bus.rsp_err   = 1'b0;
    n_cmp++;
    if (bus.rsp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rsp_accept: rsp_ready=%b want 1", bus.rsp_ready);
    end
    tick();
    bus.rsp_valid = 1'b0;
    wb_valid      = 1'b0;
    m_fetch++;
    m_stall += rw + sw;
    for (int i = 0; i <= ow; i++) begin
      bus.out_ready = (i == ow);
      bus.rsp_valid = 1'($urandom_range(0, 1));
      bus.rsp_data  = $urandom;
      wb_valid      = 1'($urandom_range(0, 1));
      wb_dnpc       = 32'h8000_1000;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_inst !== data || bus.out_pc !== m_pc) begin
        n_bad++;
        $display("FAIL hold: out_valid=%b inst=%h pc=%h, want 1 inst=%h pc=%h",
                 bus.out_valid, bus.out_inst, bus.out_pc, data, m_pc);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    wb_valid      = 1'b0;
    for (int i = 0; i < ww; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.req_valid !== 1'b0 || pc !== m_pc) begin
        n_bad++;
        $display("FAIL wb_wait: out_valid=%b req_valid=%b pc=%h, want 0/0 pc=%h",
                 bus.out_valid, bus.req_valid, pc, m_pc);
      end
      tick();
    end
    wb_valid = 1'b1;
    wb_dnpc  = dnpc;
    tick();
    wb_valid = 1'b0;
    m_pc     = dnpc;
    n_cmp++;
    if (dnpc[1:0] != 2'b00) begin
      if (fetch_err !== 1'b1 || bus.req_valid !== 1'b0 || pc !== dnpc) begin
        n_bad++;
        $display("FAIL misaligned_wb: err=%b req_valid=%b pc=%h, want 1/0 pc=%h",
                 fetch_err, bus.req_valid, pc, dnpc);
      end
    end else begin
      if (fetch_err !== 1'b0 || bus.req_valid !== 1'b1 || bus.req_addr !== dnpc) begin
        n_bad++;
        $display("FAIL next_fetch: err=%b req_valid=%b addr=%h, want 0/1 addr=%h",
                 fetch_err, bus.req_valid, bus.req_addr, dnpc);
      end
    end
`ifdef IFU_PERF_CNT_EN
    n_cmp++;
    if (perf_fetch_cnt !== 32'(m_fetch) || perf_stall_cnt !== 32'(m_stall)) begin
      n_bad++;
      $display("FAIL perf: fetch=%0d stall=%0d, want fetch=%0d stall=%0d",
               perf_fetch_cnt, perf_stall_cnt, m_fetch, m_stall);
    end
`endif
  endtask

  task automatic test_reset();
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_valid !== 1'b0 || bus.rsp_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        pc !== RST_PC || bus.out_inst !== 32'h0 || bus.out_pc !== 32'h0 || fetch_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: rv=%b rr=%b ov=%b pc=%h inst=%h opc=%h err=%b",
               bus.req_valid, bus.rsp_ready, bus.out_valid, pc, bus.out_inst, bus.out_pc, fetch_err);
    end
    tick();
    rst = 1'b1;
    #1;
    m_pc = RST_PC; m_fetch = 0; m_stall = 0;
    n_cmp++;
    if (bus.req_valid !== 1'b1 || bus.req_addr !== RST_PC) begin
      n_bad++;
      $display("FAIL reset_release: req_valid=%b addr=%h, want 1 addr=%h",
               bus.req_valid, bus.req_addr, RST_PC);
    end
  endtask

  task automatic test_first_fetch();
    run_instr(32'h0000_0413, 0, 0, 0, 0, 32'h8000_0004);
  endtask

  task automatic test_req_stall();
    run_instr($urandom, 5, 0, 0, 1, m_pc + 32'd4);
  endtask

  task automatic test_hold_stall();
    run_instr($urandom, 0, 0, 3, 0, m_pc + 32'd4);
  endtask

  task automatic test_wb_ignored();
    run_instr($urandom, 1, 4, 1, 2, m_pc + 32'd4);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++)
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom & 32'hFFFF_FFFC);
  endtask

  task automatic test_rsp_err();
    do_reset();
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_err   = 1'b1;
    bus.rsp_data  = $urandom;
    tick();
    idle_inputs();
    n_cmp++;
    if (fetch_err !== 1'b1 || pc !== m_pc) begin
      n_bad++;
      $display("FAIL rsp_err: err=%b pc=%h, want 1 pc=%h", fetch_err, pc, m_pc);
    end
    for (int i = 0; i < 20; i++) begin
      bus.req_ready = 1'($urandom_range(0, 1));
      bus.rsp_valid = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      wb_valid      = 1'($urandom_range(0, 1));
      wb_dnpc       = $urandom & 32'hFFFF_FFFC;
      n_cmp++;
      if (bus.req_valid !== 1'b0 || bus.rsp_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
          fetch_err !== 1'b1 || pc !== m_pc) begin
        n_bad++;
        $display("FAIL err_terminal: rv=%b rr=%b ov=%b err=%b pc=%h, want 0/0/0/1 pc=%h",
                 bus.req_valid, bus.rsp_ready, bus.out_valid, fetch_err, pc, m_pc);
      end
      tick();
    end
    do_reset();
    n_cmp++;
    if (fetch_err !== 1'b0 || bus.req_valid !== 1'b1 || bus.req_addr !== RST_PC) begin
      n_bad++;
      $display("FAIL err_recover: err=%b req_valid=%b addr=%h, want 0/1 addr=%h",
               fetch_err, bus.req_valid, bus.req_addr, RST_PC);
    end
  endtask

  task automatic test_misaligned_wb();
    run_instr($urandom, 0, 1, 0, 0, 32'h8000_0006);
    for (int i = 0; i < 5; i++) begin
      bus.req_ready = 1'b1;
      wb_valid      = 1'b1;
      wb_dnpc       = 32'h8000_0008;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (fetch_err !== 1'b1 || pc !== 32'h8000_0006 || bus.req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned_frozen: err=%b pc=%h rv=%b, want 1 pc=80000006 rv=0",
               fetch_err, pc, bus.req_valid);
    end
    do_reset();
  endtask

  task automatic test_reset_midflight();
    run_instr($urandom, 0, 0, 0, 0, 32'h8000_0040);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_valid !== 1'b0 || bus.rsp_ready !== 1'b0 || bus.out_valid !== 1'b0 || pc !== RST_PC) begin
      n_bad++;
      $display("FAIL reset_inflight: rv=%b rr=%b ov=%b pc=%h, want 0/0/0 pc=%h",
               bus.req_valid, bus.rsp_ready, bus.out_valid, pc, RST_PC);
    end
    tick();
    rst = 1'b1;
    m_pc = RST_PC; m_fetch = 0; m_stall = 0;
    // Stale response from the abandoned request arrives while refetching.
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (bus.req_valid !== 1'b1 || bus.req_addr !== RST_PC || bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL late_rsp: rv=%b addr=%h ov=%b, want 1 addr=%h ov=0",
                 bus.req_valid, bus.req_addr, bus.out_valid, RST_PC);
      end
      tick();
    end
    bus.rsp_valid = 1'b0;
    m_stall = 2;
    run_instr(32'h0000_0013, 0, 2, 1, 0, 32'h8000_0004);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    m_pc = RST_PC; m_fetch = 0; m_stall = 0;
    test_reset();
    test_first_fetch();
    test_req_stall();
    test_hold_stall();
    test_wb_ignored();
    test_back_to_back();
    test_rsp_err();
    test_misaligned_wb();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Multi-cycle instruction fetch stage; replaces the combinational DPI fetch in the single-cycle core.
- Holds the architectural PC and issues one read request per instruction to instruction memory over a valid/ready request/response bus.
- Presents the fetched instruction and its PC to the decode stage with a valid/ready handshake.
- Waits for the write-back commit, which carries dnpc, before fetching the next instruction. One instruction is in flight at a time.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of address and data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts the request.
- req_addr  out  XLEN  fetch address; equals pc.
- rsp_valid  in  1  memory response valid.
- rsp_ready  out  1  IFU accepts the response.
- rsp_data  in  XLEN  instruction word.
- rsp_err  in  1  access fault on this response.
- out_valid  out  1  instruction valid toward decode.
- out_ready  in  1  decode accepts the instruction.
- out_inst  out  XLEN  registered instruction.
- out_pc  out  XLEN  PC of out_inst.
- wb_valid  in  1  commit pulse from write-back.
- wb_dnpc  in  XLEN  next PC from write-back.
- pc  out  XLEN  current PC register.
- fetch_err  out  1  sticky fault flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=REQ, pc=RESET_PC.
  - out_inst=0, out_pc=0, fetch_err=0.
  - req_valid=0, rsp_ready=0 and out_valid=0 while rst is asserted.
  - Any outstanding request is abandoned; the memory model must drop its response.
- States: REQ, WAIT_RSP, HOLD, WAIT_WB, ERR. Outputs are decoded from state only (Moore).
- REQ:
  - req_valid=1, req_addr=pc.
  - req_valid stays high and req_addr stays stable until req_ready is seen.
  - On req_valid&&req_ready: go to WAIT_RSP.
- WAIT_RSP:
  - rsp_ready=1.
  - On rsp_valid&&!rsp_err: out_inst<=rsp_data, out_pc<=pc; go to HOLD.
  - On rsp_valid&&rsp_err: fetch_err<=1; go to ERR.
- rsp_valid in any state other than WAIT_RSP is ignored. A response cannot complete in the same cycle as its request.
- HOLD:
  - out_valid=1; out_inst and out_pc stay stable.
  - On out_ready: go to WAIT_WB.
- WAIT_WB:
  - On wb_valid with wb_dnpc[1:0]==0: pc<=wb_dnpc; go to REQ.
  - On wb_valid with wb_dnpc[1:0]!=0: fetch_err<=1, pc<=wb_dnpc; go to ERR.
- wb_valid in any state other than WAIT_WB is ignored.
- ERR: terminal state, all handshakes deasserted, pc frozen. Exit only through reset.
- Minimum latency is 4 cycles per instruction (REQ→WAIT_RSP→HOLD→WAIT_WB→REQ) when every peer is ready immediately.
- pc wraps modulo 2^XLEN; there is no overflow check.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds ports perf_fetch_cnt (out, 32) and perf_stall_cnt (out, 32), both reset to 0.
  - perf_fetch_cnt increments on every accepted response without error.
  - perf_stall_cnt increments on every cycle in REQ with !req_ready, and every cycle in WAIT_RSP with !rsp_valid.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ifu_pkg:
  - State enum ifu_state_t (REQ, WAIT_RSP, HOLD, WAIT_WB, ERR).
  - Constant IFU_RESET_PC.
  - Constant IFU_ALIGN_MASK = 2'b11.
- Sub-module ifu_perf_cnt: one saturating 32-bit counter, instantiated twice, only under IFU_PERF_CNT_EN.
- The FSM and the datapath stay in ifu_fetch_ctrl.

Test Plan:
1. Reset release, memory always ready and returning 32'h0000_0413 one cycle after the request → req_addr=8000_0000; out_valid rises 2 cycles after reset release; out_inst=0000_0413, out_pc=8000_0000.
2. req_ready held low for 5 cycles → req_valid stays 1 and req_addr stays stable; no state advance; perf_stall_cnt=5 when the macro is defined.
3. out_ready low for 3 cycles in HOLD → out_inst and out_pc stable; then a wb_valid with dnpc=8000_0004 → next req_addr=8000_0004.
4. wb_valid asserted during WAIT_RSP with dnpc=8000_1000 → ignored; pc unchanged.
5. Response with rsp_err=1 → fetch_err=1, state ERR; no further req_valid for 20 cycles; rst pulse → fetch_err=0, req_addr=8000_0000.
6. wb_dnpc=8000_0006 → fetch_err=1, state ERR, pc=8000_0006. Separately, rst asserted during WAIT_RSP followed by a late rsp_valid → the response is ignored and fetch restarts at RESET_PC.
